// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser
//   Consumes the SPI slave's received-byte stream and assembles LTC2668-style
//   command frames: byte0 = {cmd, addr}, byte1 = data[15:8], byte2 = data[7:0].
//   Each complete frame is presented as a one-cycle o_Cmd_DV strobe.
//   For every received byte a response byte is queued for the slave's TX side:
//   byte0 -> readback[15:8], byte1 -> readback[7:0], byte2 -> status
//   {frame_cnt, err_cnt} as it stood when byte0 arrived.
//
//   Optional build macro: SPI_CMD_CHECKSUM_EN
//     Adds a fourth byte that must equal byte0 ^ byte1 ^ byte2. Its response
//     byte is 8'hA5 on match and 8'h5A on mismatch; a mismatch drops the frame.
//
// Ports
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_RX_DV        received-byte strobe from the SPI slave
//   i_RX_Byte      received byte, valid with i_RX_DV
//   i_SPI_CS_n     raw chip select (asynchronous, synchronized here)
//   i_MISO_ready   slave can accept a TX byte
//   o_TX_DV        one-cycle TX load strobe
//   o_TX_Byte      TX byte, valid with o_TX_DV
//   i_Resp_Data    readback word, sampled when byte0 arrives
//   o_Cmd_DV       one-cycle complete-command strobe
//   o_Cmd          command nibble
//   o_Addr         channel address nibble
//   o_Data         data word
//   o_Cmd_Err      one-cycle error strobe (abort, timeout, overrun, bad checksum)
//   o_Busy         high while a frame is partially received
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | waiting for byte0 (cmd/addr)
// S_B1   | byte0 held, waiting for data high byte
// S_B2   | waiting for data low byte
// S_CHK  | waiting for checksum byte (checksum build only)

module spi_cmd_parser #(
  parameter int TIMEOUT_CLKS = 4096,
  parameter int CNT_W        = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  input  logic        i_SPI_CS_n,
  input  logic        i_MISO_ready,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic [15:0] i_Resp_Data,
  output logic        o_Cmd_DV,
  output logic [3:0]  o_Cmd,
  output logic [3:0]  o_Addr,
  output logic [15:0] o_Data,
  output logic        o_Cmd_Err,
  output logic        o_Busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {S_IDLE, S_B1, S_B2, S_CHK} state_t;

  state_t             state;
  logic               cs_meta, cs_sync, cs_sync_d;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [3:0]         cmd_l, addr_l;
  logic [7:0]         data_hi;
  logic [15:0]        resp_l;
  logic [7:0]         status_snap;
  logic [CNT_W-1:0]   frame_cnt, err_cnt;
  logic               tx_pend;
  logic [7:0]         tx_pend_byte;
`ifdef SPI_CMD_CHECKSUM_EN
  logic [7:0]         data_lo;
`endif

  logic               busy, cs_rise, tmo_hit, abort;
  logic               last_byte, cmd_ok, csum_bad;
  logic               tx_send, overrun;
  logic [7:0]         q_byte;
  logic [CNT_W-1:0]   err_inc;

  assign busy    = (state != S_IDLE);
  assign o_Busy  = busy;
  assign cs_rise = cs_sync & ~cs_sync_d;
  // The counter is reloaded on entry to a frame, so it only reaches 1 while busy
  // after TIMEOUT_CLKS idle cycles; the decrement to 0 is the abort edge.
  assign tmo_hit = (tmo_cnt <= TMO_W'(1));
  // A received byte always wins over a same-cycle abort request.
  assign abort   = busy & ~i_RX_DV & (cs_rise | tmo_hit);

`ifdef SPI_CMD_CHECKSUM_EN
  logic csum_ok;
  assign csum_ok   = (i_RX_Byte == ({cmd_l, addr_l} ^ data_hi ^ data_lo));
  assign last_byte = (state == S_CHK);
  assign cmd_ok    = i_RX_DV & last_byte & csum_ok;
  assign csum_bad  = i_RX_DV & last_byte & ~csum_ok;
`else
  assign last_byte = (state == S_B2);
  assign cmd_ok    = i_RX_DV & last_byte;
  assign csum_bad  = 1'b0;
`endif

  always_comb begin
    q_byte = 8'h00;
    case (state)
      S_IDLE:  q_byte = i_Resp_Data[15:8];
      S_B1:    q_byte = resp_l[7:0];
      S_B2:    q_byte = status_snap;
`ifdef SPI_CMD_CHECKSUM_EN
      S_CHK:   q_byte = csum_ok ? 8'hA5 : 8'h5A;
`endif
      default: q_byte = 8'h00;
    endcase
  end

  // Spacing of at least one idle cycle between TX strobes; an abort discards
  // whatever is still pending rather than sending it.
  assign tx_send = tx_pend & i_MISO_ready & ~o_TX_DV & ~abort;
  // Queuing over a byte that is not leaving this cycle loses it.
  assign overrun = i_RX_DV & tx_pend & ~tx_send;
  assign err_inc = CNT_W'(abort) + CNT_W'(overrun) + CNT_W'(csum_bad);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= S_IDLE;
      // Synchronizer idles at the deasserted CS level so reset release
      // cannot look like a rising edge.
      cs_meta      <= 1'b1;
      cs_sync      <= 1'b1;
      cs_sync_d    <= 1'b1;
      tmo_cnt      <= '0;
      cmd_l        <= '0;
      addr_l       <= '0;
      data_hi      <= '0;
      resp_l       <= '0;
      status_snap  <= '0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
      tx_pend      <= 1'b0;
      tx_pend_byte <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      data_lo      <= '0;
`endif
      o_TX_DV      <= 1'b0;
      o_TX_Byte    <= '0;
      o_Cmd_DV     <= 1'b0;
      o_Cmd        <= '0;
      o_Addr       <= '0;
      o_Data       <= '0;
      o_Cmd_Err    <= 1'b0;
    end else begin
      cs_meta   <= i_SPI_CS_n;
      cs_sync   <= cs_meta;
      cs_sync_d <= cs_sync;

      o_Cmd_DV  <= cmd_ok;
      o_Cmd_Err <= abort | overrun | csum_bad;
      err_cnt   <= err_cnt + err_inc;

      if (i_RX_DV)
        tmo_cnt <= TMO_LOAD;
      else if (busy && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TMO_W'(1);

      if (cmd_ok) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        o_Cmd     <= cmd_l;
        o_Addr    <= addr_l;
`ifdef SPI_CMD_CHECKSUM_EN
        o_Data    <= {data_hi, data_lo};
`else
        o_Data    <= {data_hi, i_RX_Byte};
`endif
      end

      if (i_RX_DV) begin
        case (state)
          S_IDLE: begin
            cmd_l       <= i_RX_Byte[7:4];
            addr_l      <= i_RX_Byte[3:0];
            resp_l      <= i_Resp_Data;
            status_snap <= 8'({frame_cnt, err_cnt});
            state       <= S_B1;
          end
          S_B1: begin
            data_hi <= i_RX_Byte;
            state   <= S_B2;
          end
          S_B2: begin
`ifdef SPI_CMD_CHECKSUM_EN
            data_lo <= i_RX_Byte;
            state   <= S_CHK;
`else
            state   <= S_IDLE;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end else if (abort) begin
        state <= S_IDLE;
      end

      o_TX_DV <= tx_send;
      if (tx_send)
        o_TX_Byte <= tx_pend_byte;

      if (i_RX_DV) begin
        tx_pend      <= 1'b1;
        tx_pend_byte <= q_byte;
      end else if (tx_send || abort) begin
        tx_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Scoreboard bench for spi_cmd_parser. A transaction-level reference model
// (frame index, readback snapshot, wrapping counters) pushes expected TX bytes,
// commands and error strobes into queues; a negedge monitor pops and compares
// whenever the DUT strobes an output.

module tb_spi_cmd_parser;

  localparam int TMO = 16;
`ifdef SPI_CMD_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        cs_n = 1'b0;
  logic        miso_ready = 1'b1;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [15:0] resp_data = 16'h0000;
  logic        cmd_dv;
  logic [3:0]  cmd, addr;
  logic [15:0] data;
  logic        cmd_err, busy;

  spi_cmd_parser #(.TIMEOUT_CLKS(TMO), .CNT_W(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .i_SPI_CS_n(cs_n), .i_MISO_ready(miso_ready), .o_TX_DV(tx_dv),
    .o_TX_Byte(tx_byte), .i_Resp_Data(resp_data), .o_Cmd_DV(cmd_dv),
    .o_Cmd(cmd), .o_Addr(addr), .o_Data(data), .o_Cmd_Err(cmd_err),
    .o_Busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int err_cyc = 0;
  bit mon_en = 1'b0;
  bit prev_tx = 1'b0;

  // reference model state
  logic [7:0]  tx_q[$];
  logic [23:0] cmd_q[$];
  int          err_pend = 0;
  logic [3:0]  m_frame = 4'd0, m_err = 4'd0;
  int          idx = 0;
  logic [15:0] m_resp;
  logic [7:0]  m_snap, m_b0, m_b1, m_b2;
  logic [23:0] last_cmd = 24'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level rules: what one received byte means for the responses,
  // the decoded command and the error count.
  task automatic model_rx(input logic [7:0] b, input bit ovr);
    logic [7:0] q;
    case (idx)
      0: begin m_resp = resp_data; m_snap = {m_frame, m_err}; m_b0 = b; q = m_resp[15:8]; end
      1: begin m_b1 = b; q = m_resp[7:0]; end
      2: begin m_b2 = b; q = m_snap; end
      default: q = (b == (m_b0 ^ m_b1 ^ m_b2)) ? 8'hA5 : 8'h5A;
    endcase
    if (ovr) begin
      tx_q[tx_q.size()-1] = q;
      m_err++;
      err_pend++;
    end else begin
      tx_q.push_back(q);
    end
    if (idx == FLEN - 1) begin
`ifdef SPI_CMD_CHECKSUM_EN
      if (b == (m_b0 ^ m_b1 ^ m_b2)) begin
        last_cmd = {m_b0, m_b1, m_b2};
        cmd_q.push_back(last_cmd);
        m_frame++;
      end else begin
        m_err++;
        err_pend++;
      end
`else
      last_cmd = {m_b0, m_b1, b};
      cmd_q.push_back(last_cmd);
      m_frame++;
`endif
      idx = 0;
    end else begin
      idx++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ovr);
    @(posedge clk); #1;
    rx_dv = 1'b1;
    rx_byte = b;
    model_rx(b, ovr);
    @(posedge clk); #1;
    rx_dv = 1'b0;
    last_rx_cyc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input int gap, input bit bad_sum);
    send_byte(a, 1'b0); check("busy_b0", busy, 1'b1); idle(gap);
    send_byte(b, 1'b0); check("busy_b1", busy, 1'b1); idle(gap);
`ifdef SPI_CMD_CHECKSUM_EN
    send_byte(c, 1'b0); check("busy_b2", busy, 1'b1); idle(gap);
    send_byte(bad_sum ? (a ^ b ^ c ^ 8'h81) : (a ^ b ^ c), 1'b0);
`else
    send_byte(bad_sum ? c : c, 1'b0);
`endif
    idle(4);
    check("busy_done", busy, 1'b0);
    check("hold_cmd", {cmd, addr, data}, last_cmd);
  endtask

  task automatic abort_cs();
    cs_n = 1'b1;
    if (idx != 0) begin m_err++; err_pend++; idx = 0; end
    idle(6);
    check("busy_after_cs", busy, 1'b0);
    cs_n = 1'b0;
    idle(4);
  endtask

  task automatic wait_timeout();
    bit had = (idx != 0);
    if (had) begin m_err++; err_pend++; idx = 0; end
    idle(TMO + 4);
    check("busy_after_tmo", busy, 1'b0);
    if (had) check("tmo_latency", err_cyc - last_rx_cyc, TMO);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_dv) begin
        check("tx_not_back_to_back", prev_tx, 1'b0);
        if (tx_q.size() == 0) check("tx_unexpected", 1'b1, 1'b0);
        else check("tx_byte", tx_byte, tx_q.pop_front());
      end
      prev_tx = tx_dv;
      if (cmd_dv) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", 1'b1, 1'b0);
        else check("cmd_frame", {cmd, addr, data}, cmd_q.pop_front());
      end
      if (cmd_err) begin
        err_cyc = cyc;
        check("err_expected", (err_pend > 0), 1'b1);
        if (err_pend > 0) err_pend--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    check("rst_tx_dv", tx_dv, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_cmd_dv", cmd_dv, 1'b0);
    check("rst_cmd_addr_data", {cmd, addr, data}, 24'h0);
    check("rst_cmd_err", cmd_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_l = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // readback then status bytes
    resp_data = 16'hBEEF;
    send_frame(8'h10, 8'h00, 8'h00, 2, 1'b0);
    // basic decode
    resp_data = 16'h1357;
    send_frame(8'h31, 8'h12, 8'h34, 1, 1'b0);
    // CS abort after two bytes, then a clean frame
    send_byte(8'h55, 1'b0); idle(1);
    send_byte(8'h66, 1'b0);
    abort_cs();
    send_frame(8'h42, 8'hAB, 8'hCD, 0, 1'b0);
    // inter-byte timeout
    send_byte(8'h77, 1'b0);
    wait_timeout();
    // TX overrun with ready held low
    miso_ready = 1'b0;
    resp_data = 16'hC0DE;
    send_byte(8'h20, 1'b0); idle(3);
    send_byte(8'h21, 1'b1); idle(3);
    miso_ready = 1'b1;
    idle(3);
    send_byte(8'h22, 1'b0);
`ifdef SPI_CMD_CHECKSUM_EN
    idle(2);
    send_byte(8'h20 ^ 8'h21 ^ 8'h22, 1'b0);
`endif
    idle(4);
`ifdef SPI_CMD_CHECKSUM_EN
    send_frame(8'h31, 8'h12, 8'h34, 1, 1'b0);
    send_frame(8'h9A, 8'h12, 8'h34, 1, 1'b1);
`endif

    for (int it = 0; it < 40; it++) begin
      int act = $urandom_range(0, 9);
      resp_data = 16'($urandom);
      if (act < 7) begin
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
                   ($urandom_range(0, 3) == 0));
      end else begin
        int nb = $urandom_range(1, FLEN - 1);
        for (int k = 0; k < nb; k++) begin
          send_byte(8'($urandom), 1'b0);
          idle($urandom_range(0, 3));
        end
        if (act < 9) abort_cs();
        else wait_timeout();
        check("hold_after_abort", {cmd, addr, data}, last_cmd);
      end
    end

    // final status frame exposes the accumulated counters
    send_frame(8'hF0, 8'h0F, 8'h5A, 2, 1'b0);
    idle(20);
    check("tx_queue_drained", tx_q.size(), 0);
    check("cmd_queue_drained", cmd_q.size(), 0);
    check("err_pulses_seen", err_pend, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
